// File: rtl/fir_sample_pacer.sv
// Sample pacer for the resource-shared FIR: buffers incoming samples in a
// circular FIFO and issues exactly one held sample per SAMPLE_PERIOD clocks.
module fir_sample_pacer #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int SAMPLE_PERIOD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         x,
  output logic                     x_strobe,
  output logic                     underrun,
  input  logic                     clr_underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(SAMPLE_PERIOD - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic wr_en, issue, pop;

  // No pass-through when full: readiness depends only on the registered count.
  assign in_ready = reset & (count_q != FULL);
  assign wr_en    = in_valid & in_ready;
  assign issue    = run & (phase_q == LAST);
  assign pop      = issue & (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    phase_d    = phase_q;
    x_d        = x_q;
    strobe_d   = issue;
    underrun_d = underrun_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (!run)                phase_d = '0;
    else if (phase_q == LAST) phase_d = '0;
    else                     phase_d = phase_q + 1'b1;

    if (issue) x_d = pop ? mem[rd_ptr_q] : '0;

    // Set has priority over a coincident clear.
    if (clr_underrun)  underrun_d = 1'b0;
    if (issue && !pop) underrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      phase_q    <= '0;
      x_q        <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      x_q        <= x_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign x        = x_q;
  assign x_strobe = strobe_q;
  assign underrun = underrun_q;
  assign level    = count_q;

endmodule
